// File: rtl/spi_pkg.sv
// Shared SPI definitions for the responder and master ends of the 16-bit link.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package spi_pkg;

   localparam int SPI_WORD_W = 16;

   // Mode 0: clock idles low, data sampled on the rising edge, MSB first.
   localparam bit SPI_CPOL      = 1'b0;
   localparam bit SPI_CPHA      = 1'b0;
   localparam bit SPI_MSB_FIRST = 1'b1;

   typedef enum logic {
      IDLE  = 1'b0,
      SHIFT = 1'b1
   } spi_state_t;

endpackage

// File: rtl/spi_sync.sv
// Synchronizes one asynchronous pin into clk and reports registered rise/fall edges.
// Latency: pin edge to rise/fall output is STAGES+1 clk cycles.
// Backpressure: none; every edge of a pin slower than clk/4 is reported once.
module spi_sync #(
   parameter int   STAGES  = 2,
   parameter logic RST_VAL = 1'b0
) (
   input  logic clk,
   input  logic reset,
   input  logic din,
   output logic rise,
   output logic fall
);

   logic [STAGES-1:0] chain_q;
   logic              dly_q;
   logic              rise_q;
   logic              fall_q;

   // Synchronizer chain, one-cycle-delayed copy and registered edge flags.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         chain_q <= {STAGES{RST_VAL}};
         dly_q   <= RST_VAL;
         rise_q  <= 1'b0;
         fall_q  <= 1'b0;
      end else begin
         chain_q <= {chain_q[STAGES-2:0], din};
         dly_q   <= chain_q[STAGES-1];
         rise_q  <= chain_q[STAGES-1] & ~dly_q;
         fall_q  <= ~chain_q[STAGES-1] & dly_q;
      end
   end

   assign rise = rise_q;
   assign fall = fall_q;

endmodule

// File: rtl/spi_slave_rx.sv
// SPI mode-0 responder: oversamples the pins, assembles WIDTH-bit words, returns a preloaded word on spi_miso.
// Latency: final spi_clk rise to rx_valid, and spi_clk fall to spi_miso update, are SYNC_STAGES+2 clk cycles.
// Backpressure: none on rx (rx_valid is a strobe); tx_load is ignored while tx_ready=0. Option macro: SPI_SLAVE_FRAME_ERR_EN.
module spi_slave_rx
   import spi_pkg::*;
#(
   parameter int WIDTH       = SPI_WORD_W,  // must be at least 3
   parameter int SYNC_STAGES = 2            // 2 or 3
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             spi_clk,
   input  logic             spi_cs,
   input  logic             spi_mosi,
   output logic             spi_miso,
   input  logic [WIDTH-1:0] tx_data,
   input  logic             tx_load,
   output logic             tx_ready,
   output logic [WIDTH-1:0] rx_data,
   output logic             rx_valid,
   output logic             busy
`ifdef SPI_SLAVE_FRAME_ERR_EN
   ,
   output logic             frame_err
`endif
);

   localparam int CNT_W = $clog2(WIDTH);
   localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

   // Edge detectors; chip select idles high so its chain resets high to avoid a false fall.
   logic clk_rise, clk_fall, cs_rise, cs_fall;

   spi_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_clk_sync (
      .clk   (clk),
      .reset (reset),
      .din   (spi_clk),
      .rise  (clk_rise),
      .fall  (clk_fall)
   );

   spi_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_cs_sync (
      .clk   (clk),
      .reset (reset),
      .din   (spi_cs),
      .rise  (cs_rise),
      .fall  (cs_fall)
   );

   // Data pin needs only the chain: the master holds mosi for half an spi_clk period around the rise.
   logic [SYNC_STAGES-1:0] mosi_q;
   logic                   mosi_sync;

   // Data pin synchronizer.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) mosi_q <= '0;
      else       mosi_q <= {mosi_q[SYNC_STAGES-2:0], spi_mosi};
   end

   assign mosi_sync = mosi_q[SYNC_STAGES-1];

   spi_state_t       state_q,    state_d;
   logic [CNT_W-1:0] bit_cnt_q,  bit_cnt_d;
   // The first WIDTH-1 bits; the last bit comes straight from mosi_sync into rx_data.
   logic [WIDTH-2:0] rx_shift_q, rx_shift_d;
   logic [WIDTH-1:0] rx_data_q,  rx_data_d;
   logic             rx_valid_q, rx_valid_d;
   logic [WIDTH-1:0] tx_shift_q, tx_shift_d;
   logic [WIDTH-1:0] hold_q,     hold_d;
   logic             hold_full_q, hold_full_d;
   // Set by a completed word so the next spi_clk fall reloads tx_shift instead of shifting.
   logic             word_done_q, word_done_d;
   logic             reload;
`ifdef SPI_SLAVE_FRAME_ERR_EN
   logic             frame_err_q, frame_err_d;
`endif

   // State and datapath registers.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q     <= IDLE;
         bit_cnt_q   <= '0;
         rx_shift_q  <= '0;
         rx_data_q   <= '0;
         rx_valid_q  <= 1'b0;
         tx_shift_q  <= '0;
         hold_q      <= '0;
         hold_full_q <= 1'b0;
         word_done_q <= 1'b0;
`ifdef SPI_SLAVE_FRAME_ERR_EN
         frame_err_q <= 1'b0;
`endif
      end else begin
         state_q     <= state_d;
         bit_cnt_q   <= bit_cnt_d;
         rx_shift_q  <= rx_shift_d;
         rx_data_q   <= rx_data_d;
         rx_valid_q  <= rx_valid_d;
         tx_shift_q  <= tx_shift_d;
         hold_q      <= hold_d;
         hold_full_q <= hold_full_d;
         word_done_q <= word_done_d;
`ifdef SPI_SLAVE_FRAME_ERR_EN
         frame_err_q <= frame_err_d;
`endif
      end
   end

   // Frame FSM, shift registers and holding-register handshake.
   always_comb begin
      state_d     = state_q;
      bit_cnt_d   = bit_cnt_q;
      rx_shift_d  = rx_shift_q;
      rx_data_d   = rx_data_q;
      rx_valid_d  = 1'b0;
      tx_shift_d  = tx_shift_q;
      hold_d      = hold_q;
      hold_full_d = hold_full_q;
      word_done_d = word_done_q;
      reload      = 1'b0;
`ifdef SPI_SLAVE_FRAME_ERR_EN
      frame_err_d = 1'b0;
`endif

      case (state_q)
         IDLE: begin
            if (cs_fall) begin
               state_d     = SHIFT;
               bit_cnt_d   = '0;
               word_done_d = 1'b0;
               reload      = 1'b1;
            end
`ifdef SPI_SLAVE_FRAME_ERR_EN
            else if (clk_rise) begin
               frame_err_d = 1'b1;
            end
`endif
         end
         SHIFT: begin
            // A chip-select rise overrides any spi_clk edge seen in the same cycle.
            if (cs_rise) begin
               state_d     = IDLE;
               bit_cnt_d   = '0;
               word_done_d = 1'b0;
`ifdef SPI_SLAVE_FRAME_ERR_EN
               frame_err_d = (bit_cnt_q != '0);
`endif
            end else if (clk_rise) begin
               if (bit_cnt_q == LAST_BIT) begin
                  rx_data_d   = {rx_shift_q, mosi_sync};
                  rx_valid_d  = 1'b1;
                  bit_cnt_d   = '0;
                  word_done_d = 1'b1;
               end else begin
                  rx_shift_d = {rx_shift_q[WIDTH-3:0], mosi_sync};
                  bit_cnt_d  = bit_cnt_q + CNT_W'(1);
               end
            end else if (clk_fall) begin
               if (word_done_q) begin
                  reload      = 1'b1;
                  word_done_d = 1'b0;
               end else begin
                  tx_shift_d = {tx_shift_q[WIDTH-2:0], 1'b0};
               end
            end
         end
         default: state_d = IDLE;
      endcase

      // A reload consumes the old holding contents; a same-cycle load below refills it for the next word.
      if (reload) begin
         tx_shift_d  = hold_full_q ? hold_q : '0;
         hold_full_d = 1'b0;
      end
      if (tx_load && !hold_full_q) begin
         hold_d      = tx_data;
         hold_full_d = 1'b1;
      end
   end

   assign spi_miso = tx_shift_q[WIDTH-1];
   assign tx_ready = ~hold_full_q;
   assign rx_data  = rx_data_q;
   assign rx_valid = rx_valid_q;
   assign busy     = (state_q == SHIFT);
`ifdef SPI_SLAVE_FRAME_ERR_EN
   assign frame_err = frame_err_q;
`endif

endmodule

// File: tb/tb_spi_slave_rx.sv
// Directed bench for spi_slave_rx: master model at clk/8, mode 0, MSB first.
// Latency: checks rx_valid arrives 4 clk cycles after the last spi_clk rise.
// Backpressure: exercises tx_load while tx_ready=0.
module tb_spi_slave_rx;

   logic        clk;
   logic        reset;
   logic        spi_clk;
   logic        spi_cs;
   logic        spi_mosi;
   logic        spi_miso;
   logic [15:0] tx_data;
   logic        tx_load;
   logic        tx_ready;
   logic [15:0] rx_data;
   logic        rx_valid;
   logic        busy;
`ifdef SPI_SLAVE_FRAME_ERR_EN
   logic        frame_err;
   int          err_cnt = 0;
`endif

   int          n_checks = 0;
   int          n_pass   = 0;
   int          rx_cnt   = 0;
   logic [15:0] rx_log [8];
   time         rx_time  = 0;
   time         last_rise_t = 0;

   spi_slave_rx dut (
      .clk      (clk),
      .reset    (reset),
      .spi_clk  (spi_clk),
      .spi_cs   (spi_cs),
      .spi_mosi (spi_mosi),
      .spi_miso (spi_miso),
      .tx_data  (tx_data),
      .tx_load  (tx_load),
      .tx_ready (tx_ready),
      .rx_data  (rx_data),
      .rx_valid (rx_valid),
      .busy     (busy)
`ifdef SPI_SLAVE_FRAME_ERR_EN
      ,
      .frame_err(frame_err)
`endif
   );

   // Posedges at 5+10k; all stimulus changes land on negedges (multiples of 10).
   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (rx_valid) begin
         rx_log[rx_cnt % 8] = rx_data;
         rx_cnt  = rx_cnt + 1;
         rx_time = $time;
      end
`ifdef SPI_SLAVE_FRAME_ERR_EN
      if (frame_err) err_cnt = err_cnt + 1;
`endif
   end

   task automatic load_tx(input logic [15:0] d);
      tx_data = d;
      tx_load = 1'b1;
      #10;
      tx_load = 1'b0;
   endtask

   task automatic frame_begin();
      spi_cs = 1'b0;
      #80;
   endtask

   task automatic frame_end();
      #40;
      spi_cs = 1'b1;
      #80;
   endtask

   // Shifts the top nbits of mo; mi collects spi_miso as the master samples it at each rise.
   task automatic spi_bits(input logic [15:0] mo, input int nbits, output logic [15:0] mi);
      mi = '0;
      for (int i = 0; i < nbits; i++) begin
         spi_mosi = mo[15-i];
         #40;
         mi[15-i]    = spi_miso;
         spi_clk     = 1'b1;
         last_rise_t = $time;
         #40;
         spi_clk = 1'b0;
      end
   endtask

   task automatic test_reset();
      n_checks++; if (spi_miso !== 1'b0) $display("FAIL reset_miso: got %b want 0", spi_miso); else n_pass++;
      n_checks++; if (rx_data !== 16'h0000) $display("FAIL reset_rx_data: got %h want 0000", rx_data); else n_pass++;
      n_checks++; if (rx_valid !== 1'b0) $display("FAIL reset_rx_valid: got %b want 0", rx_valid); else n_pass++;
      n_checks++; if (tx_ready !== 1'b1) $display("FAIL reset_tx_ready: got %b want 1", tx_ready); else n_pass++;
      n_checks++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", busy); else n_pass++;
`ifdef SPI_SLAVE_FRAME_ERR_EN
      n_checks++; if (frame_err !== 1'b0) $display("FAIL reset_frame_err: got %b want 0", frame_err); else n_pass++;
`endif
   endtask

   task automatic test_basic();
      logic [15:0] mi;
      int base;
      base = rx_cnt;
      load_tx(16'hA5C3);
      n_checks++; if (tx_ready !== 1'b0) $display("FAIL basic_ready_loaded: got %b want 0", tx_ready); else n_pass++;
      frame_begin();
      n_checks++; if (tx_ready !== 1'b1) $display("FAIL basic_ready_start: got %b want 1", tx_ready); else n_pass++;
      n_checks++; if (busy !== 1'b1) $display("FAIL basic_busy: got %b want 1", busy); else n_pass++;
      spi_bits(16'h1234, 16, mi);
      frame_end();
      n_checks++; if (rx_cnt - base !== 1) $display("FAIL basic_rx_pulses: got %0d want 1", rx_cnt - base); else n_pass++;
      n_checks++; if (rx_log[base % 8] !== 16'h1234) $display("FAIL basic_rx_data: got %h want 1234", rx_log[base % 8]); else n_pass++;
      n_checks++; if (mi !== 16'hA5C3) $display("FAIL basic_miso: got %h want a5c3", mi); else n_pass++;
      n_checks++; if (rx_time - last_rise_t !== 40) $display("FAIL basic_latency: got %0t want 40 (4 cycles)", rx_time - last_rise_t); else n_pass++;
      n_checks++; if (busy !== 1'b0) $display("FAIL basic_busy_end: got %b want 0", busy); else n_pass++;
   endtask

   task automatic test_no_preload();
      logic [15:0] mi;
      int base;
      base = rx_cnt;
      frame_begin();
      spi_bits(16'hFFFF, 16, mi);
      frame_end();
      n_checks++; if (mi !== 16'h0000) $display("FAIL nopre_miso: got %h want 0000", mi); else n_pass++;
      n_checks++; if (rx_cnt - base !== 1) $display("FAIL nopre_rx_pulses: got %0d want 1", rx_cnt - base); else n_pass++;
      n_checks++; if (rx_data !== 16'hFFFF) $display("FAIL nopre_rx_data: got %h want ffff", rx_data); else n_pass++;
   endtask

   task automatic test_back_to_back();
      logic [15:0] mi1, mi2;
      int base;
      base = rx_cnt;
      load_tx(16'h1357);
      frame_begin();
      fork
         begin
            spi_bits(16'h0001, 16, mi1);
            spi_bits(16'h8000, 16, mi2);
         end
         begin
            #200;
            n_checks++; if (tx_ready !== 1'b1) $display("FAIL b2b_ready: got %b want 1", tx_ready); else n_pass++;
            load_tx(16'hBEEF);
         end
      join
      frame_end();
      n_checks++; if (rx_cnt - base !== 2) $display("FAIL b2b_rx_pulses: got %0d want 2", rx_cnt - base); else n_pass++;
      n_checks++; if (rx_log[base % 8] !== 16'h0001) $display("FAIL b2b_rx0: got %h want 0001", rx_log[base % 8]); else n_pass++;
      n_checks++; if (rx_log[(base + 1) % 8] !== 16'h8000) $display("FAIL b2b_rx1: got %h want 8000", rx_log[(base + 1) % 8]); else n_pass++;
      n_checks++; if (mi1 !== 16'h1357) $display("FAIL b2b_miso0: got %h want 1357", mi1); else n_pass++;
      n_checks++; if (mi2 !== 16'hBEEF) $display("FAIL b2b_miso1: got %h want beef", mi2); else n_pass++;
   endtask

   task automatic test_abort();
      logic [15:0] mi;
      int base;
`ifdef SPI_SLAVE_FRAME_ERR_EN
      int ebase;
      ebase = err_cnt;
`endif
      base = rx_cnt;
      frame_begin();
      fork
         spi_bits(16'hFE00, 7, mi);
         begin
            #200;
            load_tx(16'h0F0F);
         end
      join
      frame_end();
      n_checks++; if (rx_cnt - base !== 0) $display("FAIL abort_no_rx: got %0d want 0", rx_cnt - base); else n_pass++;
      n_checks++; if (tx_ready !== 1'b0) $display("FAIL abort_hold_kept: got %b want 0", tx_ready); else n_pass++;
      n_checks++; if (busy !== 1'b0) $display("FAIL abort_busy: got %b want 0", busy); else n_pass++;
`ifdef SPI_SLAVE_FRAME_ERR_EN
      n_checks++; if (err_cnt - ebase !== 1) $display("FAIL abort_frame_err: got %0d want 1", err_cnt - ebase); else n_pass++;
`endif
      frame_begin();
      spi_bits(16'h5A5A, 16, mi);
      frame_end();
      n_checks++; if (rx_cnt - base !== 1) $display("FAIL abort_next_pulses: got %0d want 1", rx_cnt - base); else n_pass++;
      n_checks++; if (rx_data !== 16'h5A5A) $display("FAIL abort_next_rx: got %h want 5a5a", rx_data); else n_pass++;
      n_checks++; if (mi !== 16'h0F0F) $display("FAIL abort_next_miso: got %h want 0f0f", mi); else n_pass++;
   endtask

`ifdef SPI_SLAVE_FRAME_ERR_EN
   task automatic test_idle_clk();
      int ebase;
      int base;
      ebase = err_cnt;
      base  = rx_cnt;
      spi_clk = 1'b1;
      #40;
      spi_clk = 1'b0;
      #80;
      n_checks++; if (err_cnt - ebase !== 1) $display("FAIL idle_clk_err: got %0d want 1", err_cnt - ebase); else n_pass++;
      n_checks++; if (rx_cnt - base !== 0) $display("FAIL idle_clk_rx: got %0d want 0", rx_cnt - base); else n_pass++;
   endtask
`endif

   task automatic test_reset_mid_frame();
      logic [15:0] mi;
      int base;
      load_tx(16'hFFFF);
      frame_begin();
      spi_bits(16'h0000, 9, mi);
      load_tx(16'h9ABC);
      n_checks++; if (tx_ready !== 1'b0) $display("FAIL rst_mid_loaded: got %b want 0", tx_ready); else n_pass++;
      reset = 1'b1;
      #1;
      n_checks++; if (spi_miso !== 1'b0) $display("FAIL rst_mid_miso: got %b want 0", spi_miso); else n_pass++;
      n_checks++; if (rx_data !== 16'h0000) $display("FAIL rst_mid_rx_data: got %h want 0000", rx_data); else n_pass++;
      n_checks++; if (rx_valid !== 1'b0) $display("FAIL rst_mid_rx_valid: got %b want 0", rx_valid); else n_pass++;
      n_checks++; if (tx_ready !== 1'b1) $display("FAIL rst_mid_tx_ready: got %b want 1", tx_ready); else n_pass++;
      n_checks++; if (busy !== 1'b0) $display("FAIL rst_mid_busy: got %b want 0", busy); else n_pass++;
      #9;
      spi_cs  = 1'b1;
      spi_clk = 1'b0;
      #20;
      reset = 1'b0;
      #40;
      base = rx_cnt;
      load_tx(16'h7777);
      frame_begin();
      spi_bits(16'h2468, 16, mi);
      frame_end();
      n_checks++; if (rx_cnt - base !== 1) $display("FAIL rst_next_pulses: got %0d want 1", rx_cnt - base); else n_pass++;
      n_checks++; if (rx_data !== 16'h2468) $display("FAIL rst_next_rx: got %h want 2468", rx_data); else n_pass++;
      n_checks++; if (mi !== 16'h7777) $display("FAIL rst_next_miso: got %h want 7777", mi); else n_pass++;
   endtask

   task automatic test_double_load();
      logic [15:0] mi;
      n_checks++; if (tx_ready !== 1'b1) $display("FAIL dbl_ready_init: got %b want 1", tx_ready); else n_pass++;
      load_tx(16'h1111);
      n_checks++; if (tx_ready !== 1'b0) $display("FAIL dbl_ready_first: got %b want 0", tx_ready); else n_pass++;
      load_tx(16'h2222);
      n_checks++; if (tx_ready !== 1'b0) $display("FAIL dbl_ready_second: got %b want 0", tx_ready); else n_pass++;
      frame_begin();
      n_checks++; if (tx_ready !== 1'b1) $display("FAIL dbl_ready_start: got %b want 1", tx_ready); else n_pass++;
      spi_bits(16'h0000, 16, mi);
      frame_end();
      n_checks++; if (mi !== 16'h1111) $display("FAIL dbl_miso: got %h want 1111", mi); else n_pass++;
      n_checks++; if (rx_data !== 16'h0000) $display("FAIL dbl_rx: got %h want 0000", rx_data); else n_pass++;
   endtask

   initial begin
      reset    = 1'b1;
      spi_clk  = 1'b0;
      spi_cs   = 1'b1;
      spi_mosi = 1'b0;
      tx_data  = '0;
      tx_load  = 1'b0;
      #40;
      reset = 1'b0;
      #20;
      test_reset();
      test_basic();
      test_no_preload();
      test_back_to_back();
      test_abort();
`ifdef SPI_SLAVE_FRAME_ERR_EN
      test_idle_clk();
`endif
      test_reset_mid_frame();
      test_double_load();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
